instr_fetch: RTL and testbench

Instruction fetch initiator for the single-cycle RISC-V core. Owns the program counter, drives addresses into the combinational instruction ROM (window 0x0040_0000–0x0040_0FFF, zero returned outside), and buffers fetched words in a 2-entry prefetch FIFO. Words are presented to decode with a valid/ready handshake. Branch/jump redirects flush the buffer and restart fetch.

---
 rtl/instr_fetch.sv | 116 +++++++++++
 tb/tb_instr_fetch.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, fetches from the ROM, buffers words in a 2-entry FIFO.
// Define FETCH_ALIGN_CHECK_EN to keep misaligned redirect targets and fault on them.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter logic [31:0] IMEM_BASE = 32'h0040_0000,
    parameter logic [31:0] IMEM_LAST = 32'h0040_0FFF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
    output logic        fetch_fault
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] fpc_q [2];
    logic [31:0] fpc_d [2];
    logic [31:0] fdata_q [2];
    logic [31:0] fdata_d [2];
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        fault_q, fault_d;

    logic        align_ok;
    logic        pc_legal;
    logic        push;
    logic        pop;
    logic [31:0] redir_target;

`ifdef FETCH_ALIGN_CHECK_EN
    assign align_ok     = (pc_q[1:0] == 2'b00);
    assign redir_target = redirect_pc;
`else
    assign align_ok     = 1'b1;
    assign redir_target = redirect_pc & 32'hFFFF_FFFC;
`endif

    assign pc_legal = (pc_q >= IMEM_BASE) && (pc_q <= (IMEM_LAST - 32'd3)) && align_ok;

    assign inst_valid  = (count_q != 2'd0);
    assign pop         = inst_valid && inst_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle
    assign push        = !redirect_valid && !fault_q && pc_legal
                         && ((count_q < 2'd2) || pop);

    assign imem_addr   = pc_q;
    assign fetch_fault = fault_q;
    assign inst_pc     = inst_valid ? fpc_q[rd_ptr_q]   : 32'h0;
    assign inst_data   = inst_valid ? fdata_q[rd_ptr_q] : 32'h0;

    always_comb begin
        pc_d     = pc_q;
        fpc_d    = fpc_q;
        fdata_d  = fdata_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        fault_d  = fault_q;

        if (redirect_valid) begin
            pc_d     = redir_target;
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            fault_d  = 1'b0;
        end else begin
            if (push) begin
                fpc_d[wr_ptr_q]   = pc_q;
                fdata_d[wr_ptr_q] = imem_data;
                wr_ptr_d          = ~wr_ptr_q;
                pc_d              = pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
            if (!pc_legal && !fault_q) begin
                fault_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            fpc_q[0]   <= 32'h0;
            fpc_q[1]   <= 32'h0;
            fdata_q[0] <= 32'h0;
            fdata_q[1] <= 32'h0;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            fpc_q    <= fpc_d;
            fdata_q  <= fdata_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            fault_q  <= fault_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a ROM model and an expected-word scoreboard.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        fetch_fault;

    int tests = 0;
    int fails = 0;
    logic [63:0] sb[$];

    instr_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_pc       (inst_pc),
        .inst_data     (inst_data),
        .fetch_fault   (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a >= 32'h0040_0000 && a <= 32'h0040_0FFC)
            return {~a[15:0], a[15:0]};
        return 32'h0;
    endfunction

    assign imem_data = rom(imem_addr);

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push_stream(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            a = base + 32'(4 * i);
            sb.push_back({a, rom(a)});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle; a head accepted by decode is checked against the scoreboard
    task automatic cyc();
        if (inst_valid && inst_ready && !redirect_valid) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL sb_unexpected observed=%h expected=none",
                       {inst_pc, inst_data});
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                chk("sb_head", {inst_pc, inst_data}, e);
            end
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        inst_ready = 1'b0;
        #12;
        chk("rst_valid", 64'(inst_valid), 64'd0);
        chk("rst_pc", 64'(inst_pc), 64'd0);
        chk("rst_data", 64'(inst_data), 64'd0);
        chk("rst_fault", 64'(fetch_fault), 64'd0);
        chk("rst_addr", 64'(imem_addr), 64'h0040_0000);

        // Backpressure
        tick();
        rst = 1'b0;
        push_stream(32'h0040_0000, 6);
        repeat (5) cyc();
        chk("bp_addr", 64'(imem_addr), 64'h0040_0008);
        chk("bp_valid", 64'(inst_valid), 64'd1);
        chk("bp_head", {inst_pc, inst_data}, {32'h0040_0000, rom(32'h0040_0000)});
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 64'(inst_valid), 64'd1);
            cyc();
        end

        // Redirect with full FIFO and a pop in the same cycle
        redirect_valid = 1'b1;
        redirect_pc = 32'h0040_0100;
        sb.delete();
        push_stream(32'h0040_0100, 3);
        cyc();
        redirect_valid = 1'b0;
        chk("redir_valid", 64'(inst_valid), 64'd0);
        chk("redir_addr", 64'(imem_addr), 64'h0040_0100);
        cyc();
        chk("redir_first", {63'd0, inst_valid}, 64'd1);
        chk("redir_pc", 64'(inst_pc), 64'h0040_0100);
        repeat (3) cyc();

        // Window end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0040_0FFC;
        sb.delete();
        push_stream(32'h0040_0FFC, 1);
        cyc();
        redirect_valid = 1'b0;
        chk("end_addr0", 64'(imem_addr), 64'h0040_0FFC);
        cyc();
        chk("end_valid", 64'(inst_valid), 64'd1);
        chk("end_addr1", 64'(imem_addr), 64'h0040_1000);
        chk("end_nofault", 64'(fetch_fault), 64'd0);
        cyc();
        chk("end_fault", 64'(fetch_fault), 64'd1);
        chk("end_empty", 64'(inst_valid), 64'd0);
        repeat (3) cyc();
        chk("end_still_empty", 64'(inst_valid), 64'd0);
        chk("end_still_fault", 64'(fetch_fault), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0040_0000;
        push_stream(32'h0040_0000, 2);
        cyc();
        redirect_valid = 1'b0;
        chk("clr_fault", 64'(fetch_fault), 64'd0);
        chk("clr_addr", 64'(imem_addr), 64'h0040_0000);
        cyc();
        chk("resume_valid", 64'(inst_valid), 64'd1);
        chk("resume_pc", 64'(inst_pc), 64'h0040_0000);
        repeat (2) cyc();

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc = 32'h0040_0102;
        sb.delete();
`ifndef FETCH_ALIGN_CHECK_EN
        push_stream(32'h0040_0100, 2);
`endif
        cyc();
        redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis_addr", 64'(imem_addr), 64'h0040_0102);
        cyc();
        chk("mis_fault", 64'(fetch_fault), 64'd1);
        chk("mis_nopush", 64'(inst_valid), 64'd0);
        cyc();
        chk("mis_nopush2", 64'(inst_valid), 64'd0);
`else
        chk("mis_addr", 64'(imem_addr), 64'h0040_0100);
        cyc();
        chk("mis_pc", 64'(inst_pc), 64'h0040_0100);
        chk("mis_nofault", 64'(fetch_fault), 64'd0);
        repeat (2) cyc();
`endif

        // Asynchronous reset with a full FIFO
        inst_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0040_0200;
        sb.delete();
        cyc();
        redirect_valid = 1'b0;
        repeat (3) cyc();
        chk("full_addr", 64'(imem_addr), 64'h0040_0208);
        chk("full_valid", 64'(inst_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(inst_valid), 64'd0);
        chk("arst_fault", 64'(fetch_fault), 64'd0);
        chk("arst_addr", 64'(imem_addr), 64'h0040_0000);
        chk("arst_pc", 64'(inst_pc), 64'd0);

        // Reset release and stream
        tick();
        rst = 1'b0;
        inst_ready = 1'b1;
        push_stream(32'h0040_0000, 4);
        chk("rel_valid", 64'(inst_valid), 64'd0);
        cyc();
        chk("lat_valid", 64'(inst_valid), 64'd1);
        chk("lat_head", {inst_pc, inst_data}, {32'h0040_0000, rom(32'h0040_0000)});
        for (int i = 0; i < 3; i++) begin
            chk("stream_valid", 64'(inst_valid), 64'd1);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
